// File: rtl/axi_fifo_slave_mc.sv
// axi_fifo_slave_mc: multi-channel AXI4 slave exposing NUM_CH show-ahead line
// FIFOs plus an edge-triggered, maskable interrupt controller. The read and
// write paths are independent FSMs. Bursts are fixed-address, so every beat of
// a burst targets the address latched at the address handshake.
module axi_fifo_slave_mc #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h000F_0000,
    parameter int                    NUM_CH     = 4,
    parameter int                    FIFO_DW    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    // read address channel
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [ID_WIDTH-1:0]       arid,
    input  logic [7:0]                arlen,
    input  logic                      arvalid,
    output logic                      arready,
    // read data channel
    output logic [31:0]               rdata,
    output logic [ID_WIDTH-1:0]       rid,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready,
    // write address channel
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [ID_WIDTH-1:0]       awid,
    input  logic [7:0]                awlen,
    input  logic                      awvalid,
    output logic                      awready,
    // write data channel
    input  logic [31:0]               wdata,
    input  logic [3:0]                wstrb,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    // write response channel
    output logic [ID_WIDTH-1:0]       bid,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    // FIFO side
    input  logic [NUM_CH*FIFO_DW-1:0] i_fifo_data,
    input  logic [NUM_CH-1:0]         i_fifo_empty,
    output logic [NUM_CH-1:0]         o_fifo_rd_en,
    // interrupt side
    input  logic [NUM_CH-1:0]         i_evt,
    output logic                      o_interrupt
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_DATA = 1'b1;

    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_DATA = 2'd1;
    localparam logic [1:0] WR_RESP = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]            rd_state_q, rd_state_d;
    logic                  arready_q, arready_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ID_WIDTH-1:0]   rd_id_q, rd_id_d;
    logic [7:0]            rd_len_q, rd_len_d;
    logic [7:0]            rd_cnt_q, rd_cnt_d;

    logic [1:0]            wr_state_q, wr_state_d;
    logic                  awready_q, awready_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ID_WIDTH-1:0]   wr_id_q, wr_id_d;
    logic [1:0]            bresp_q, bresp_d;

    logic [NUM_CH-1:0]     status_q, status_d;
    logic [NUM_CH-1:0]     mask_q, mask_d;
    logic [NUM_CH-1:0]     evt_q, evt_d;
    logic                  irq_q, irq_d;

    // ------------------------------------------------------------------
    // Address decode (offset from base, byte offset bits ignored)
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] rd_off, wr_off;
    logic [IDX_W-1:0]      rd_idx, wr_idx;
    logic                  rd_is_status, rd_is_mask;
    logic                  wr_is_status, wr_is_mask;
    logic [NUM_CH-1:0]     rd_fifo_hit, wr_fifo_hit;
    logic [FIFO_DW-1:0]    fifo_head [NUM_CH];

    assign rd_off       = rd_addr_q - BASE_ADDR;
    assign wr_off       = wr_addr_q - BASE_ADDR;
    assign rd_idx       = rd_off[ADDR_WIDTH-1:2];
    assign wr_idx       = wr_off[ADDR_WIDTH-1:2];
    assign rd_is_status = (rd_idx == '0);
    assign rd_is_mask   = (rd_idx == IDX_W'(1));
    assign wr_is_status = (wr_idx == '0);
    assign wr_is_mask   = (wr_idx == IDX_W'(1));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign rd_fifo_hit[gi] = (rd_idx == IDX_W'(gi + 2));
            assign wr_fifo_hit[gi] = (wr_idx == IDX_W'(gi + 2));
            assign fifo_head[gi]   = i_fifo_data[gi*FIFO_DW +: FIFO_DW];
        end
    endgenerate

    // Byte-lane enables expanded to a 32-bit bit mask.
    logic [31:0] wr_lane_mask;
    logic [31:0] wr_bits;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_lane_mask[gi*8 +: 8] = {8{wstrb[gi]}};
        end
    endgenerate

    assign wr_bits = wdata & wr_lane_mask;

    // ------------------------------------------------------------------
    // Read data path: data/response come straight from the target so a
    // FIFO head or a status bit is always shown at its current value.
    // ------------------------------------------------------------------
    logic [31:0]       rd_data;
    logic [1:0]        rd_resp;
    logic [NUM_CH-1:0] rd_pop;

    // Select read data, response and pop strobe for the current beat.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        rd_pop  = '0;
        if (rd_state_q == RD_DATA) begin
            if (rd_is_status) begin
                rd_data = 32'(status_q);
            end else if (rd_is_mask) begin
                rd_data = 32'(mask_q);
            end else if (|rd_fifo_hit) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (rd_fifo_hit[k]) begin
                        if (i_fifo_empty[k]) begin
                            // Empty FIFO: error beat, burst keeps going, no pop.
                            rd_resp = RESP_SLVERR;
                        end else begin
                            rd_data   = 32'(fifo_head[k]);
                            rd_pop[k] = rready;
                        end
                    end
                end
            end else begin
                rd_resp = RESP_DECERR;
            end
        end
    end

    // Read FSM next state: accept AR in IDLE, stream len+1 beats in RDATA.
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rd_addr_d  = rd_addr_q;
        rd_id_d    = rd_id_q;
        rd_len_d   = rd_len_q;
        rd_cnt_d   = rd_cnt_q;
        case (rd_state_q)
            RD_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    rd_addr_d  = araddr;
                    rd_id_d    = arid;
                    rd_len_d   = arlen;
                    rd_cnt_d   = '0;
                    arready_d  = 1'b0;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rready) begin
                    if (rd_cnt_q == rd_len_q) begin
                        rd_state_d = RD_IDLE;
                        arready_d  = 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                rd_state_d = RD_IDLE;
                arready_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic       wr_fire;
    logic [1:0] wr_beat_resp;

    assign wr_fire = (wr_state_q == WR_DATA) && wvalid;

    // Per-beat response depends only on the latched target.
    always_comb begin
        wr_beat_resp = RESP_DECERR;
        if (wr_is_status || wr_is_mask) begin
            wr_beat_resp = RESP_OKAY;
        end else if (|wr_fifo_hit) begin
            wr_beat_resp = RESP_SLVERR;
        end
    end

    // Write FSM next state: AW in IDLE, data beats until wlast, then B.
    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = awready_q;
        wr_addr_d  = wr_addr_q;
        wr_id_d    = wr_id_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            WR_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    wr_addr_d  = awaddr;
                    wr_id_d    = awid;
                    bresp_d    = RESP_OKAY;
                    awready_d  = 1'b0;
                    wr_state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (wvalid) begin
                    // Any error beat sticks into the final response.
                    if (wr_beat_resp != RESP_OKAY) begin
                        bresp_d = wr_beat_resp;
                    end
                    if (wlast) begin
                        wr_state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (bready) begin
                    wr_state_d = WR_IDLE;
                    awready_d  = 1'b1;
                end
            end
            default: begin
                wr_state_d = WR_IDLE;
                awready_d  = 1'b0;
            end
        endcase
    end

    // Interrupt registers: W1C clear first, then event rises set bits so a
    // same-cycle set always wins over the clear.
    always_comb begin
        evt_d    = i_evt;
        status_d = status_q;
        mask_d   = mask_q;
        if (wr_fire && wr_is_status) begin
            status_d = status_q & ~wr_bits[NUM_CH-1:0];
        end
        status_d = status_d | (i_evt & ~evt_q);
        if (wr_fire && wr_is_mask) begin
            mask_d = (mask_q & ~wr_lane_mask[NUM_CH-1:0]) | wr_bits[NUM_CH-1:0];
        end
        irq_d = |(status_q & mask_q);
    end

    // All state flops, cleared asynchronously so a reset abandons any burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rd_addr_q  <= '0;
            rd_id_q    <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_id_q    <= '0;
            bresp_q    <= RESP_OKAY;
            status_q   <= '0;
            mask_q     <= '0;
            evt_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rd_addr_q  <= rd_addr_d;
            rd_id_q    <= rd_id_d;
            rd_len_q   <= rd_len_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wr_addr_q  <= wr_addr_d;
            wr_id_q    <= wr_id_d;
            bresp_q    <= bresp_d;
            status_q   <= status_d;
            mask_q     <= mask_d;
            evt_q      <= evt_d;
            irq_q      <= irq_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign arready      = arready_q;
    assign rvalid       = (rd_state_q == RD_DATA);
    assign rdata        = rd_data;
    assign rresp        = rd_resp;
    assign rid          = rd_id_q;
    assign rlast        = (rd_state_q == RD_DATA) && (rd_cnt_q == rd_len_q);
    assign o_fifo_rd_en = rd_pop;

    assign awready      = awready_q;
    assign wready       = (wr_state_q == WR_DATA);
    assign bvalid       = (wr_state_q == WR_RESP);
    assign bresp        = bresp_q;
    assign bid          = wr_id_q;

    assign o_interrupt  = irq_q;

    // Bits that carry no information for this register map.
    logic unused_bits;
    assign unused_bits = ^{awlen, rd_off[1:0], wr_off[1:0],
                           wr_bits[31:NUM_CH], wr_lane_mask[31:NUM_CH]};

endmodule

// File: tb/tb_axi_fifo_slave_mc.sv
// Testbench for axi_fifo_slave_mc: directed plus randomized AXI transactions
// checked against a behavioural model of FIFOs and interrupt registers.
module tb_axi_fifo_slave_mc;

    localparam int          NCH  = 4;
    localparam int          FDW  = 16;
    localparam logic [31:0] BASE = 32'h000F_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       araddr, awaddr, wdata, rdata;
    logic [3:0]        arid, awid, rid, bid, wstrb;
    logic [7:0]        arlen, awlen;
    logic              arvalid, arready, rvalid, rready, rlast;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [1:0]        rresp, bresp;
    logic [NCH*FDW-1:0] i_fifo_data;
    logic [NCH-1:0]    i_fifo_empty, o_fifo_rd_en, i_evt;
    logic              o_interrupt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [FDW-1:0] fq [NCH][$];
    int             pop_cnt [NCH];
    logic [NCH-1:0] mask_exp, status_exp;

    // Captured read beats of the most recent burst
    logic [31:0] cap_data [256];
    logic [1:0]  cap_resp [256];
    logic        cap_last [256];
    logic [3:0]  cap_id   [256];

    always #5 clk = ~clk;

    axi_fifo_slave_mc #(
        .ADDR_WIDTH(32), .ID_WIDTH(4), .BASE_ADDR(BASE), .NUM_CH(NCH), .FIFO_DW(FDW)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty), .o_fifo_rd_en(o_fifo_rd_en),
        .i_evt(i_evt), .o_interrupt(o_interrupt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present FIFO heads; an empty FIFO shows junk data that must not leak.
    task automatic refresh();
        for (int k = 0; k < NCH; k++) begin
            i_fifo_empty[k] = (fq[k].size() == 0);
            i_fifo_data[k*FDW +: FDW] = (fq[k].size() != 0) ? fq[k][0] : 16'hDEAD;
        end
    endtask

    task automatic fill(input int k, input int n);
        fq[k].delete();
        for (int i = 0; i < n; i++) fq[k].push_back(16'($urandom));
        refresh();
    endtask

    // FIFO model: pop the head whenever the DUT strobes a read enable.
    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (o_fifo_rd_en[k]) begin
                pop_cnt[k]++;
                if (fq[k].size() != 0) void'(fq[k].pop_front());
            end
        end
        refresh();
    end

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                            input int mode, output int nb);
        int t;
        @(negedge clk);
        araddr = addr; arid = id; arlen = 8'(len); arvalid = 1'b1; t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        chk("ar_ready", 32'(arready), 1);
        @(negedge clk);
        arvalid = 1'b0;
        nb = 0; t = 0;
        while (nb <= len && t < 2000) begin
            rready = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
            #1;
            if (rvalid && rready) begin
                cap_data[nb] = rdata; cap_resp[nb] = rresp;
                cap_last[nb] = rlast; cap_id[nb] = rid;
                nb++;
            end
            @(negedge clk);
            t++;
        end
        rready = 1'b0;
        $display("read  addr=%h id=%0d len=%0d beats=%0d", addr, id, len, nb);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                             input logic [31:0] data, input logic [3:0] strb,
                             input logic [NCH-1:0] evt,
                             output logic [1:0] resp, output logic [3:0] bid_o);
        int t;
        @(negedge clk);
        awaddr = addr; awid = id; awlen = 8'(len); awvalid = 1'b1; t = 0;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        chk("aw_ready", 32'(awready), 1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wdata = data; wstrb = strb; wlast = (i == len); wvalid = 1'b1;
            if (i == len) i_evt = evt;
            t = 0;
            while (!wready && t < 50) begin @(negedge clk); t++; end
            chk("w_ready", 32'(wready), 1);
            @(negedge clk);
            i_evt = '0;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1; t = 0;
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        chk("b_valid", 32'(bvalid), 1);
        resp = bresp; bid_o = bid;
        @(negedge clk);
        bready = 1'b0;
        $display("write addr=%h id=%0d len=%0d data=%h strb=%h bresp=%0d", addr, id, len, data, strb, resp);
    endtask

    // Read a burst and compare every beat with what the model predicts.
    task automatic do_read_check(input string tag, input logic [31:0] addr, input int len,
                                 input int mode);
        logic [31:0]    off, ed;
        logic [1:0]     er;
        logic [3:0]     id;
        logic [FDW-1:0] snap [$];
        int             w, ch, nb;
        int             base_pops [NCH];
        int             exp_pops [NCH];
        off = addr - BASE;
        w   = int'(off >> 2);
        ch  = w - 2;
        id  = 4'($urandom);
        for (int k = 0; k < NCH; k++) begin base_pops[k] = pop_cnt[k]; exp_pops[k] = 0; end
        if (w >= 2 && w < 2 + NCH) begin
            snap = fq[ch];
            exp_pops[ch] = (len + 1 < snap.size()) ? len + 1 : snap.size();
        end
        axi_read(addr, id, len, mode, nb);
        chk($sformatf("%s_beats", tag), nb, len + 1);
        for (int i = 0; i < nb && i <= len; i++) begin
            if (w == 0) begin ed = 32'(status_exp); er = 2'b00; end
            else if (w == 1) begin ed = 32'(mask_exp); er = 2'b00; end
            else if (w >= 2 && w < 2 + NCH) begin
                if (i < snap.size()) begin ed = 32'(snap[i]); er = 2'b00; end
                else begin ed = 0; er = 2'b10; end
            end else begin ed = 0; er = 2'b11; end
            chk($sformatf("%s_b%0d_data", tag, i), cap_data[i], ed);
            chk($sformatf("%s_b%0d_resp", tag, i), 32'(cap_resp[i]), 32'(er));
            chk($sformatf("%s_b%0d_last", tag, i), 32'(cap_last[i]), 32'(i == len));
            chk($sformatf("%s_b%0d_id", tag, i), 32'(cap_id[i]), 32'(id));
        end
        for (int k = 0; k < NCH; k++)
            chk($sformatf("%s_pops_ch%0d", tag, k), pop_cnt[k] - base_pops[k], exp_pops[k]);
        chk($sformatf("%s_rvalid_after", tag), 32'(rvalid), 0);
        chk($sformatf("%s_arready_after", tag), 32'(arready), 1);
    endtask

    task automatic do_write_check(input string tag, input logic [31:0] addr, input int len,
                                  input logic [31:0] data, input logic [3:0] strb,
                                  input logic [1:0] exp_resp, input logic [NCH-1:0] evt);
        logic [1:0] resp;
        logic [3:0] b_id, id;
        id = 4'($urandom);
        axi_write(addr, id, len, data, strb, evt, resp, b_id);
        chk($sformatf("%s_bresp", tag), 32'(resp), 32'(exp_resp));
        chk($sformatf("%s_bid", tag), 32'(b_id), 32'(id));
    endtask

    task automatic pulse_evt(input int k);
        @(negedge clk); i_evt[k] = 1'b1;
        @(negedge clk); i_evt[k] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  s;
        int          ch, len, n, p0, t;
        araddr = '0; arid = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awid = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        i_evt = '0;
        status_exp = '0; mask_exp = '0;
        refresh();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_arready", 32'(arready), 0);
        chk("rst_awready", 32'(awready), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_wready", 32'(wready), 0);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rlast", 32'(rlast), 0);
        chk("rst_resp", 32'({rresp, bresp}), 0);
        chk("rst_rd_en", 32'(o_fifo_rd_en), 0);
        chk("rst_irq", 32'(o_interrupt), 0);
        rst = 1'b0;
        #1;
        chk("rel_arready_pre_edge", 32'(arready), 0);
        @(negedge clk);
        chk("rel_arready", 32'(arready), 1);
        chk("rel_awready", 32'(awready), 1);
        chk("rel_rvalid", 32'(rvalid), 0);
        chk("rel_bvalid", 32'(bvalid), 0);
        chk("rel_irq", 32'(o_interrupt), 0);

        // FIFO burst with rready toggling
        fq[2].delete();
        fq[2].push_back(16'h1111); fq[2].push_back(16'h2222);
        fq[2].push_back(16'h3333); fq[2].push_back(16'h4444);
        refresh();
        do_read_check("fifo2", BASE + 32'h10, 3, 1);

        // Burst longer than FIFO contents
        fq[0].delete(); fq[0].push_back(16'hABCD); refresh();
        do_read_check("fifo0_empty", BASE + 32'h08, 1, 0);

        // Randomized FIFO bursts
        repeat (8) begin
            ch  = $urandom_range(0, NCH - 1);
            n   = $urandom_range(0, 6);
            len = $urandom_range(0, 7);
            fill(ch, n);
            do_read_check($sformatf("rnd_fifo%0d", ch), BASE + 32'(8 + 4 * ch), len, $urandom_range(0, 2));
        end

        // Randomized byte-lane writes to INT_MASK
        repeat (4) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write_check("mask_wr", BASE + 32'h4, 0, d, s, 2'b00, '0);
            for (int b = 0; b < NCH; b++) if (s[b / 8]) mask_exp[b] = d[b];
            do_read_check("mask_rd", BASE + 32'h4, 1, 2);
        end

        // Interrupt flow
        do_write_check("mask2", BASE + 32'h4, 0, 32'h2, 4'hF, 2'b00, '0);
        mask_exp = 4'h2;
        do_write_check("clr_all", BASE, 0, 32'hF, 4'hF, 2'b00, '0);
        status_exp = '0;
        pulse_evt(1);
        status_exp[1] = 1'b1;
        chk("irq_after_evt1", 32'(o_interrupt), 1);
        do_read_check("status_a", BASE, 0, 0);
        pulse_evt(0);
        status_exp[0] = 1'b1;
        do_read_check("status_b", BASE, 1, 1);
        do_write_check("w1c_bit1", BASE, 0, 32'h2, 4'hF, 2'b00, '0);
        status_exp[1] = 1'b0;
        @(negedge clk);
        chk("irq_after_w1c", 32'(o_interrupt), 0);
        do_read_check("status_c", BASE, 0, 0);
        do_write_check("w1c_vs_evt", BASE, 0, 32'h2, 4'hF, 2'b00, 4'b0010);
        status_exp[1] = 1'b1;
        @(negedge clk);
        chk("irq_set_wins", 32'(o_interrupt), 1);
        do_read_check("status_d", BASE, 0, 0);
        do_write_check("w1c_burst", BASE, 2, 32'h1, 4'h1, 2'b00, '0);
        status_exp[0] = 1'b0;
        do_read_check("status_e", BASE, 0, 0);

        // Error responses
        do_read_check("unmapped_rd", BASE + 32'h100, 2, 0);
        do_read_check("below_base_rd", BASE - 32'h4, 0, 0);
        do_write_check("wr_fifo1", BASE + 32'h0C, 0, 32'h1234, 4'hF, 2'b10, '0);
        do_write_check("wr_unmapped", BASE + 32'h200, 1, 32'h5678, 4'hF, 2'b11, '0);
        do_read_check("mask_after_err", BASE + 32'h4, 0, 0);

        // Reset in the middle of a FIFO burst
        fill(3, 8);
        p0 = pop_cnt[3];
        @(negedge clk);
        araddr = BASE + 32'h14; arid = 4'h5; arlen = 8'd7; arvalid = 1'b1; rready = 1'b1; t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        chk("mb_ar_ready", 32'(arready), 1);
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        #1;
        chk("mb_beat2_rvalid", 32'(rvalid), 1);
        chk("mb_beat2_rd_en", 32'(o_fifo_rd_en), 32'h8);
        rst = 1'b1;
        #1;
        chk("mb_rst_rvalid", 32'(rvalid), 0);
        chk("mb_rst_rd_en", 32'(o_fifo_rd_en), 0);
        chk("mb_rst_rdata", rdata, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0; rready = 1'b0;
        status_exp = '0; mask_exp = '0;
        chk("mb_pop_count", pop_cnt[3] - p0, 1);
        @(negedge clk);
        do_read_check("post_rst_fifo3", BASE + 32'h14, 2, 0);
        do_read_check("post_rst_status", BASE, 0, 0);
        chk("post_rst_irq", 32'(o_interrupt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
